// File: rtl/ipmred_encoder.sv
// ipmred_encoder: sequential inner-product-masking encoder for one GF(2^8) secret byte.
// Latency: accept at cycle t, v-1 multiply-accumulate cycles, out_valid_o from cycle t+v.
// Backpressure: holds z_o/out_valid_o stable in DONE until out_ready_i; in_ready_o only when idle.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   in_valid_i / in_ready_o       request handshake carrying x_i, l_i, rand_i
//   x_i                           secret byte
//   l_i                           public vector, byte i at [8i+7:8i] (byte 0 expected 0x01)
//   rand_i                        random shares M[1..v-1], M[i] at [8(i-1)+7:8(i-1)]
//   out_valid_o / out_ready_i     result handshake
//   z_o                           encoding, byte i at [8i+7:8i]
module ipmred_encoder #(
  parameter int unsigned v = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [7:0]           x_i,
  input  logic [v*8-1:0]       l_i,
  input  logic [(v-1)*8-1:0]   rand_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [v*8-1:0]       z_o
);

  localparam int unsigned CW    = (v > 2) ? $clog2(v) : 1;
  // Operand tables are sized to the full index range so any cnt value selects a defined entry.
  localparam int unsigned NSLOT = 1 << CW;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [v*8-1:0]       l_q;
  logic [(v-1)*8-1:0]   m_q;
  logic [7:0]           acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [v*8-1:0]       z_q, z_d;
  logic                 load;

  logic [7:0]           l_slot [NSLOT];
  logic [7:0]           m_slot [NSLOT];
  logic [7:0]           prod;

  // GF(2^8) multiply, modulus x^8+x^4+x^3+x+1: shift-and-add with xtime reduction.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Byte 0 of L pairs with a zero share: slot 0 is never selected while accumulating.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      l_slot[i] = 8'h00;
      m_slot[i] = 8'h00;
    end
    l_slot[0] = l_q[7:0];
    for (int i = 1; i < v; i++) begin
      l_slot[i] = l_q[8*i +: 8];
      m_slot[i] = m_q[8*(i-1) +: 8];
    end
  end

  // The single shared multiplier.
  assign prod = gf_mul(l_slot[cnt_q], m_slot[cnt_q]);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          load    = 1'b1;
          acc_d   = x_i;
          cnt_d   = CW'(1);
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q ^ prod;
        if (cnt_q == CW'(v - 1)) begin
          // Last term: publish shares with the freshly completed byte 0; cnt stays at v-1.
          z_d     = {m_q, acc_q ^ prod};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= 8'h00;
      cnt_q   <= '0;
      z_q     <= '0;
      l_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      if (load) begin
        l_q <= l_i;
        m_q <= rand_i;
      end
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign z_o         = z_q;

endmodule

// File: doc/ipmred_encoder.md
Name: ipmred_encoder

Overview:
- Sequential IPM encoder directly upstream of the IPM-RED point-addition stage.
- Turns one secret GF(2^8) byte X into a v-share inner-product-masking encoding Z under public vector L.
- Produces the Z / Z_ operands that the adder consumes; instantiate twice for the two operands.
- Uses a single shared GF(2^8) multiplier iterated over the shares, to save area.

Parameters:
- v, 8, number of shares (bytes per encoding); legal range 2..16.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request carries valid X/L/rand
- in_ready  output  1  encoder idle, request accepted when in_valid & in_ready
- X  input  8  secret byte
- L  input  v*8  public vector, byte i at [8i+7:8i]; L[0] must be 0x01 (not checked)
- rand  input  (v-1)*8  random shares M[1..v-1], M[i] at [8(i-1)+7:8(i-1)]
- out_valid  output  1  Z holds a complete encoding
- out_ready  input  1  consumer takes Z when out_valid & out_ready
- Z  output  v*8  encoding, byte i at [8i+7:8i]

Behaviour:
- Field: GF(2^8), reduction polynomial x^8+x^4+x^3+x+1 (0x11B). Addition is XOR.
- Encoding rule:
  - Z[i] = M[i] for i = 1..v-1.
  - Z[0] = X xor (XOR over i=1..v-1 of L[i]·M[i]).
  - Hence XOR over i of L[i]·Z[i] = X.
- Datapath registers: X_r, L_r, M_r, acc (8 bit), index cnt (clog2(v) bits, minimum 1), state.
- Multiplier: one combinational GF(2^8) multiplier, operands L_r[cnt] and M_r[cnt]. No other multipliers.
- FSM states: IDLE, MAC, DONE.
  - IDLE: in_ready=1. On in_valid, latch X/L/rand, set acc<=X and cnt<=1, go to MAC.
  - MAC: each cycle, acc <= acc xor L_r[cnt]·M_r[cnt] and cnt <= cnt+1. When cnt==v-1, go to DONE and load Z <= {M_r, acc_next}.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Timing: handshake in cycle t → exactly v-1 MAC cycles → out_valid high from cycle t+v.
- Throughput: one encoding per v+1 cycles with out_ready held high; the next in_ready is seen the cycle after the output handshake.
- in_ready is 1 only in IDLE. in_valid in MAC or DONE is ignored; inputs need not be held after acceptance.
- Backpressure: in DONE with out_ready=0, Z and out_valid stay stable indefinitely.
- Output registers: Z is registered and changes only on the MAC→DONE transition. After the output handshake Z retains its last value; consumers must qualify with out_valid.
- Reset: rst=1 forces state=IDLE, out_valid=0, Z=0, acc=0, cnt=0 and in_ready=1 (after the edge).
  - Reset mid-MAC or in DONE discards the operation; no out_valid is produced.
  - rst has priority over in_valid in the same cycle.
- Boundary case v=2: exactly one MAC cycle, out_valid at t+2.
- cnt never exceeds v-1; no wrap-around occurs.
- No dependence on L[0]; byte 0 is always the computed share.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1 → after release, in_ready=1, out_valid=0, Z=0, and no spurious output.
2. v=2: X=0x00, L={0x57,0x01}, rand=0x83, accepted at cycle t → out_valid at t+2, Z={0x83,0xC1}.
3. v=3: X=0x12, L={0x57,0x57,0x01}, M1=0x83, M2=0x13 → Z={0x13,0x83,0x2D}; decode check XOR L[i]·Z[i]=0x12.
4. Backpressure (v=3): out_ready=0 for 5 cycles in DONE, in_valid=1 toggling with new X → Z and out_valid stable, in_ready=0, no second accept; out_ready=1 → in_ready=1 the next cycle.
5. Reset mid-operation (v=8): assert rst at cycle t+3 → state IDLE, out_valid never asserts, Z=0; the following request encodes correctly.
6. v=8 random regression: 1000 requests with random X/L (L[0]=0x01)/rand and random out_ready → each Z decodes to X, Z[7..1]=rand, and accept-to-valid latency = 8 cycles.
